anim_channels: RTL and testbench

Multi-channel, frame-synchronous parameter animator for the render clock domain. It generalises the hand-written per-frame offset counters into N independently configured channels, for example object position, rotation sin/cos pair index, or colour phase. Each channel has its own step, bounds, boundary mode and frame divider. Outputs feed `triangle_feeder` offsets and `render_manager` transform fields, and are updated atomically once per `begin_frame`.

---
 rtl/anim_pkg.sv | 38 +++
 rtl/anim_step.sv | 90 +++++++++
 rtl/anim_channels.sv | 179 +++++++++++++++++
 tb/tb_anim_channels.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Shared types for the frame-synchronous parameter animator:
// boundary modes, config field codes and sweep states.
package anim_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_WRAP   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_CLAMP  = 2'd3
    } anim_mode_t;

    localparam logic [2:0] FLD_VALUE = 3'd0;
    localparam logic [2:0] FLD_STEP  = 3'd1;
    localparam logic [2:0] FLD_MIN   = 3'd2;
    localparam logic [2:0] FLD_MAX   = 3'd3;
    localparam logic [2:0] FLD_MODE  = 3'd4;
    localparam logic [2:0] FLD_DIV   = 3'd5;

    typedef enum logic [2:0] {
        FIELD_VALUE = FLD_VALUE,
        FIELD_STEP  = FLD_STEP,
        FIELD_MIN   = FLD_MIN,
        FIELD_MAX   = FLD_MAX,
        FIELD_MODE  = FLD_MODE,
        FIELD_DIV   = FLD_DIV
    } anim_field_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SWEEP   = 2'd1,
        ST_PUBLISH = 2'd2
    } anim_state_t;

    function automatic anim_mode_t mode_from_bits(input logic [1:0] bits);
        return anim_mode_t'(bits);
    endfunction

endpackage

// File: rtl/anim_step.sv
// Combinational step rule for one channel; shared by the sweep.
// All compares run in W+1 bits so value+step cannot overflow.
module anim_step
    import anim_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] step,
    input  logic [W-1:0] min_lim,
    input  logic [W-1:0] max_lim,
    input  anim_mode_t   mode,
    output logic [W-1:0] next_value,
    output logic [W-1:0] next_step
);

    // Negation that maps the most-negative step onto the most-positive one.
    function automatic logic [W-1:0] neg_sat(input logic [W-1:0] s);
        if (s == {1'b1, {(W-1){1'b0}}}) begin
            neg_sat = {1'b0, {(W-1){1'b1}}};
        end else begin
            neg_sat = ~s + {{(W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic signed [W:0] sum_s;
    logic signed [W:0] min_x_s;
    logic signed [W:0] max_x_s;
    logic              above_s;
    logic              below_s;
    logic              inverted_s;

    assign sum_s      = $signed({value[W-1], value}) + $signed({step[W-1], step});
    assign min_x_s    = $signed({min_lim[W-1], min_lim});
    assign max_x_s    = $signed({max_lim[W-1], max_lim});
    assign above_s    = (sum_s > max_x_s);
    assign below_s    = (sum_s < min_x_s);
    assign inverted_s = (min_x_s > max_x_s);

    // Boundary handling per mode; an inverted range freezes the channel.
    always_comb begin
        next_value = value;
        next_step  = step;
        if (inverted_s) begin
            next_value = value;
            next_step  = step;
        end else begin
            case (mode)
                MODE_WRAP: begin
                    if (above_s) begin
                        next_value = min_lim;
                    end else if (below_s) begin
                        next_value = max_lim;
                    end else begin
                        next_value = sum_s[W-1:0];
                    end
                end
                MODE_BOUNCE: begin
                    if (above_s) begin
                        next_value = max_lim;
                        next_step  = neg_sat(step);
                    end else if (below_s) begin
                        next_value = min_lim;
                        next_step  = neg_sat(step);
                    end else begin
                        next_value = sum_s[W-1:0];
                    end
                end
                MODE_CLAMP: begin
                    if (above_s) begin
                        next_value = max_lim;
                    end else if (below_s) begin
                        next_value = min_lim;
                    end else begin
                        next_value = sum_s[W-1:0];
                    end
                end
                MODE_HOLD: begin
                    next_value = value;
                    next_step  = step;
                end
                default: begin
                    next_value = value;
                    next_step  = step;
                end
            endcase
        end
    end

endmodule

// File: rtl/anim_channels.sv
// N-channel parameter animator: one channel stepped per cycle after each
// frame tick, then all values published together on a single edge.
module anim_channels
    import anim_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int W     = 32,
    parameter  int DIV_W = 8,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [2:0]        cfg_field,
    input  logic [W-1:0]      cfg_data,
    output logic [N_CH*W-1:0] out_value,
    output logic              update_done,
    output logic              busy,
    output logic              overrun
);

    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(N_CH - 1);

    logic [W-1:0]     value_r   [N_CH];
    logic [W-1:0]     step_r    [N_CH];
    logic [W-1:0]     min_r     [N_CH];
    logic [W-1:0]     max_r     [N_CH];
    anim_mode_t       mode_r    [N_CH];
    logic [DIV_W-1:0] div_r     [N_CH];
    logic [DIV_W-1:0] div_cnt_r [N_CH];

    anim_state_t      state_r;
    anim_state_t      state_nxt_s;
    logic [CH_W-1:0]  idx_r;
    logic [N_CH*W-1:0] out_value_r;
    logic             busy_r;
    logic             update_done_r;
    logic             overrun_r;

    logic             sweep_en_s;
    logic             publish_s;
    logic             drop_s;
    logic             cfg_ready_s;
    logic             cfg_we_s;
    logic             cfg_in_range_s;
    logic [W-1:0]     next_value_s;
    logic [W-1:0]     next_step_s;

    anim_step #(.W(W)) u_step (
        .value      (value_r[idx_r]),
        .step       (step_r[idx_r]),
        .min_lim    (min_r[idx_r]),
        .max_lim    (max_r[idx_r]),
        .mode       (mode_r[idx_r]),
        .next_value (next_value_s),
        .next_step  (next_step_s)
    );

    assign cfg_in_range_s = ({{(32-CH_W){1'b0}}, cfg_ch} < N_CH);

    // State register and sweep index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {CH_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_IDLE) begin
                idx_r <= {CH_W{1'b0}};
            end else if ((state_r == ST_SWEEP) && (idx_r != LAST_IDX)) begin
                idx_r <= idx_r + {{(CH_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick) begin
                    state_nxt_s = ST_SWEEP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = ST_PUBLISH;
                end else begin
                    state_nxt_s = ST_SWEEP;
                end
            end
            ST_PUBLISH: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State-decoded strobes; a tick outranks a config write.
    always_comb begin
        sweep_en_s  = (state_r == ST_SWEEP);
        publish_s   = (state_r == ST_PUBLISH);
        drop_s      = tick && (state_r != ST_IDLE);
        cfg_ready_s = (state_r == ST_IDLE) && !tick;
        cfg_we_s    = cfg_valid && cfg_ready_s && cfg_in_range_s;
    end

    // Per-channel working state: sweep update or config write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                value_r[i]   <= {W{1'b0}};
                step_r[i]    <= {W{1'b0}};
                min_r[i]     <= {W{1'b0}};
                max_r[i]     <= {W{1'b0}};
                mode_r[i]    <= MODE_HOLD;
                div_r[i]     <= {DIV_W{1'b0}};
                div_cnt_r[i] <= {DIV_W{1'b0}};
            end
        end else if (sweep_en_s) begin
            if (div_cnt_r[idx_r] != div_r[idx_r]) begin
                div_cnt_r[idx_r] <= div_cnt_r[idx_r] + {{(DIV_W-1){1'b0}}, 1'b1};
            end else begin
                div_cnt_r[idx_r] <= {DIV_W{1'b0}};
                value_r[idx_r]   <= next_value_s;
                step_r[idx_r]    <= next_step_s;
            end
        end else if (cfg_we_s) begin
            case (anim_field_t'(cfg_field))
                FIELD_VALUE: value_r[cfg_ch] <= cfg_data;
                FIELD_STEP:  step_r[cfg_ch]  <= cfg_data;
                FIELD_MIN:   min_r[cfg_ch]   <= cfg_data;
                FIELD_MAX:   max_r[cfg_ch]   <= cfg_data;
                FIELD_MODE:  mode_r[cfg_ch]  <= mode_from_bits(cfg_data[1:0]);
                FIELD_DIV: begin
                    div_r[cfg_ch]     <= cfg_data[DIV_W-1:0];
                    div_cnt_r[cfg_ch] <= {DIV_W{1'b0}};
                end
                default: ;
            endcase
        end
    end

    // Published values: whole-vector copy on publish, single slice on VALUE write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_value_r <= {(N_CH*W){1'b0}};
        end else if (publish_s) begin
            for (int i = 0; i < N_CH; i++) begin
                out_value_r[i*W +: W] <= value_r[i];
            end
        end else if (cfg_we_s && (cfg_field == FLD_VALUE)) begin
            out_value_r[cfg_ch*W +: W] <= cfg_data;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r        <= 1'b0;
            update_done_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            busy_r        <= (state_nxt_s != ST_IDLE);
            update_done_r <= publish_s;
            overrun_r     <= drop_s;
        end
    end

    assign cfg_ready   = cfg_ready_s;
    assign out_value   = out_value_r;
    assign update_done = update_done_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_anim_channels.sv
// Self-checking bench for anim_channels: a frame-level model compared every
// cycle, plus hand-computed values for the WRAP/BOUNCE/DIV/overrun/reset cases.
module tb_anim_channels;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           tick = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [1:0]     cfg_ch = 2'd0;
    logic [2:0]     cfg_field = 3'd0;
    logic [31:0]    cfg_data = 32'd0;
    logic [N*W-1:0] out_value;
    logic           update_done;
    logic           busy;
    logic           overrun;

    int checks = 0;
    int errors = 0;

    anim_channels #(.N_CH(N), .W(W), .DIV_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_field   (cfg_field),
        .cfg_data    (cfg_data),
        .out_value   (out_value),
        .update_done (update_done),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    int m_val [N];
    int m_stp [N];
    int m_min [N];
    int m_max [N];
    int m_mode[N];
    int m_div [N];
    int m_cnt [N];
    int m_out [N];
    int pend = 0;
    bit exp_busy = 1'b0;
    bit exp_done = 1'b0;
    bit exp_ovr  = 1'b0;
    bit chk_en   = 1'b0;

    function automatic int neg_sat(input int s);
        if (s == int'(32'h8000_0000)) return int'(32'h7FFF_FFFF);
        return -s;
    endfunction

    task automatic apply_rule(input int c);
        longint s;
        s = longint'(m_val[c]) + longint'(m_stp[c]);
        if (m_min[c] > m_max[c]) return;
        case (m_mode[c])
            1: m_val[c] = (s > m_max[c]) ? m_min[c] : (s < m_min[c]) ? m_max[c] : int'(s);
            2: begin
                if (s > m_max[c]) begin
                    m_val[c] = m_max[c]; m_stp[c] = neg_sat(m_stp[c]);
                end else if (s < m_min[c]) begin
                    m_val[c] = m_min[c]; m_stp[c] = neg_sat(m_stp[c]);
                end else m_val[c] = int'(s);
            end
            3: m_val[c] = (s > m_max[c]) ? m_max[c] : (s < m_min[c]) ? m_min[c] : int'(s);
            default: ;
        endcase
    endtask

    task automatic model_frame();
        for (int c = 0; c < N; c++) begin
            if (m_cnt[c] != m_div[c]) m_cnt[c]++;
            else begin
                m_cnt[c] = 0;
                apply_rule(c);
            end
        end
    endtask

    task automatic model_cfg();
        int c;
        c = int'(cfg_ch);
        case (cfg_field)
            3'd0: begin m_val[c] = int'(cfg_data); m_out[c] = int'(cfg_data); end
            3'd1: m_stp[c] = int'(cfg_data);
            3'd2: m_min[c] = int'(cfg_data);
            3'd3: m_max[c] = int'(cfg_data);
            3'd4: m_mode[c] = int'(cfg_data[1:0]);
            3'd5: begin m_div[c] = int'(cfg_data[7:0]); m_cnt[c] = 0; end
            default: ;
        endcase
    endtask

    initial begin : model
        bit idle;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                for (int c = 0; c < N; c++) begin
                    m_val[c] = 0; m_stp[c] = 0; m_min[c] = 0; m_max[c] = 0;
                    m_mode[c] = 0; m_div[c] = 0; m_cnt[c] = 0; m_out[c] = 0;
                end
                pend = 0; exp_busy = 1'b0; exp_done = 1'b0; exp_ovr = 1'b0;
            end else begin
                idle = (pend == 0);
                exp_done = 1'b0;
                exp_ovr  = 1'b0;
                if (!idle) begin
                    pend--;
                    if (pend == 0) begin
                        for (int c = 0; c < N; c++) m_out[c] = m_val[c];
                        exp_done = 1'b1;
                        exp_busy = 1'b0;
                    end
                end
                if (tick) begin
                    if (idle) begin
                        model_frame();
                        pend = N + 1;
                        exp_busy = 1'b1;
                    end else begin
                        exp_ovr = 1'b1;
                    end
                end else if (cfg_valid && idle) begin
                    model_cfg();
                end
            end
        end
    end

    // Cycle-by-cycle comparison, sampled on the falling edge.
    initial begin : compare
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int c = 0; c < N; c++) e[c*32 +: 32] = m_out[c];
                check("model_out_value", out_value, e);
                check("model_busy", busy, exp_busy);
                check("model_update_done", update_done, exp_done);
                check("model_overrun", overrun, exp_ovr);
                check("model_cfg_ready", cfg_ready, (pend == 0) && !tick);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input int fld, input logic [31:0] d);
        int n;
        n = 0;
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_field = 3'(fld); cfg_data = d;
        #1;
        while (!cfg_ready && n < 50) begin step_clk(); n++; end
        if (!cfg_ready) check("cfg_ready_timeout", cfg_ready, 1);
        step_clk();
        cfg_valid = 1'b0;
    endtask

    task automatic do_tick(output int lat);
        tick = 1'b1;
        step_clk();
        tick = 1'b0;
        lat = 0;
        do begin step_clk(); lat++; end while (!update_done && lat < 40);
    endtask

    function automatic logic [31:0] ch_val(input int c);
        return out_value[c*32 +: 32];
    endfunction

    initial begin : stim
        int lat, ov, dn;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_out_value", out_value, 128'h0);
        check("reset_busy", busy, 1'b0);
        check("reset_update_done", update_done, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_cfg_ready", cfg_ready, 1'b1);

        // ch0 WRAP, ch1 BOUNCE, ch2 CLAMP with DIV=2
        cfg_write(0, 2, 32'hFFB0_0000); cfg_write(0, 3, 32'h0050_0000);
        cfg_write(0, 1, 32'h0000_8000); cfg_write(0, 0, 32'h004F_8000);
        cfg_write(0, 4, 32'd1);
        cfg_write(1, 2, 32'h0);         cfg_write(1, 3, 32'h0003_0000);
        cfg_write(1, 1, 32'h0002_0000); cfg_write(1, 0, 32'h0002_0000);
        cfg_write(1, 4, 32'd2);
        cfg_write(2, 2, 32'd0); cfg_write(2, 3, 32'd10); cfg_write(2, 1, 32'd1);
        cfg_write(2, 4, 32'd3); cfg_write(2, 5, 32'd2);
        check("cfg_value_slice_ch0", ch_val(0), 32'h004F_8000);

        do_tick(lat);
        check("tick_latency", lat, 5);
        check("wrap_t1", ch_val(0), 32'h0050_0000);
        check("bounce_t1", ch_val(1), 32'h0003_0000);
        check("div_t1", ch_val(2), 32'd0);
        do_tick(lat);
        check("wrap_t2", ch_val(0), 32'hFFB0_0000);
        check("bounce_t2", ch_val(1), 32'h0001_0000);
        check("div_t2", ch_val(2), 32'd0);
        do_tick(lat);
        check("wrap_t3", ch_val(0), 32'hFFB0_8000);
        check("div_t3", ch_val(2), 32'd1);
        do_tick(lat); do_tick(lat);
        check("div_t5", ch_val(2), 32'd1);
        do_tick(lat);
        check("div_t6", ch_val(2), 32'd2);
        cfg_write(2, 0, 32'd9);
        repeat (3) do_tick(lat);
        check("clamp_t9", ch_val(2), 32'd10);
        repeat (3) do_tick(lat);
        check("clamp_t12", ch_val(2), 32'd10);

        // Second tick during a sweep is dropped
        ov = 0; dn = 0;
        tick = 1'b1; step_clk(); tick = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k == 1) tick = 1'b1;
            if (k == 2) tick = 1'b0;
            ov += int'(overrun);
            dn += int'(update_done);
            step_clk();
        end
        check("overrun_pulses", ov, 1);
        check("overrun_done_pulses", dn, 1);
        check("overrun_single_step", ch_val(0), 32'hFFB5_8000);

        // Tick and config write in the same idle cycle
        tick = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_field = 3'd0; cfg_data = 32'h0001_2345;
        #1;
        check("ready_low_with_tick", cfg_ready, 1'b0);
        step_clk();
        tick = 1'b0;
        lat = 0;
        do begin step_clk(); lat++; end while (!update_done && lat < 40);
        check("held_write_latency", lat, 5);
        check("held_write_not_taken", ch_val(3), 32'h0);
        check("ready_at_done", cfg_ready, 1'b1);
        step_clk();
        cfg_valid = 1'b0;
        check("held_write_visible", ch_val(3), 32'h0001_2345);

        // Reset in the middle of a sweep
        tick = 1'b1; step_clk(); tick = 1'b0;
        step_clk();
        rst_n = 1'b0;
        step_clk();
        rst_n = 1'b1;
        check("midreset_busy", busy, 1'b0);
        check("midreset_out_value", out_value, 128'h0);
        dn = 0;
        for (int k = 0; k < 8; k++) begin dn += int'(update_done); step_clk(); end
        check("midreset_no_done", dn, 0);
        cfg_write(0, 0, 32'd5);
        cfg_write(0, 1, 32'd1);
        do_tick(lat);
        check("midreset_latency", lat, 5);
        check("midreset_hold_mode", ch_val(0), 32'd5);

        repeat (3) step_clk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
